apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
APB responder (completer) register bank. It sits on one Pselx line at the peripheral end of the AHB-to-APB bridge. It decodes APB setup/access phases, stores or returns 32-bit word registers, and inserts programmable wait states via Pready. Illegal accesses are flagged on Pslverr. With WAIT_STATES=0 it is zero-wait and compatible with bridges that ignore Pready.

Parameters:
NUM_REGS, 16, number of 32-bit registers (power of 2, 2..256); index 0 is a read-only ID register.
WAIT_STATES, 0, extra access-phase cycles before Pready (0..15).
ID_VALUE, 32'hA5B0_0001, constant returned by register 0.

Ports:
Hclk  in  1  clock, rising edge.
Hresetn  in  1  asynchronous active-low reset.
Psel  in  1  select; one bit of the bridge Pselx.
Penable  in  1  access-phase strobe.
Pwrite  in  1  1 = write, 0 = read.
Paddr  in  32  byte address; only the offset bits Paddr[11:0] are decoded.
Pwdata  in  32  write data.
Prdata  out  32  read data, valid while Pready=1 on a read.
Pready  out  1  transfer completes this cycle.
Pslverr  out  1  error response; valid only with Pready=1.

Behaviour:
- Reset, asynchronous on Hresetn low:
  - FSM=IDLE, wait counter=0.
  - Prdata=0, Pready=0, Pslverr=0.
  - Registers 1..NUM_REGS-1 = 0. Register 0 always reads ID_VALUE.
- Index = Paddr[AW+1:2], where AW = clog2(NUM_REGS).
- Error conditions, evaluated in the setup cycle and latched:
  - Paddr[1:0] != 0.
  - Paddr[11:AW+2] != 0.
  - Write to index 0.
- FSM states IDLE and ACCESS.
  - IDLE → ACCESS when Psel=1 and Penable=0 (setup cycle). On that edge, latch index, Pwrite and the error flag; load counter=WAIT_STATES.
  - On a read setup, Prdata is registered on the same edge: reg[index], or 0 if in error.
  - ACCESS: Pready = (counter==0), combinational from registered state. Pslverr = Pready & latched error.
  - Counter decrements each ACCESS cycle while it is nonzero.
  - Completion happens on the edge where Psel=1, Penable=1 and Pready=1. If the transfer is a write with no error, reg[index] <= Pwdata. State → IDLE.
  - Prdata returns to 0 on the edge after completion.
- Back-to-back transfers: a new setup in the cycle after completion is accepted normally (IDLE sees Psel=1, Penable=0). Zero-wait throughput is one transfer per 2 cycles.
- Psel deasserted during ACCESS: abort, → IDLE, no register write, Pready=0.
- Penable=1 while in IDLE (protocol violation): ignored, stays IDLE, Pready=0.
- Paddr, Pwrite and Pwdata changing during ACCESS:
  - Latched index and direction are used.
  - Pwdata is sampled at the completion edge.
- Failed writes (error) leave all registers unchanged. Erroring reads return 0.
- Reset mid-transfer: immediate return to reset values; no partial write.

Decomposition:
- Shared package apb_pkg:
  - FSM state typedef (IDLE, ACCESS).
  - APB_DATA_W=32, APB_OFFSET_W=12.
  - Default ID constant.
- One natural sub-module, apb_wait_counter: load/decrement/zero-flag counter, reusable by other APB peripherals.
- Register array and decode stay in the top.

Test Plan:
1. Reset; read Paddr=0x000 → Prdata=32'hA5B0_0001, Pready=1 in the first Penable cycle, Pslverr=0. Read 0x004 → 0.
2. Write 0x008 ← 32'hDEAD_BEEF, then read 0x008 → 32'hDEAD_BEEF. Back-to-back with no idle cycle, each transfer takes 2 cycles.
3. WAIT_STATES=3: write and read 0x03C → Pready low for 3 Penable cycles, high on the 4th; data 32'h1234_5678 round-trips.
4. Errors, each giving Pslverr=1 with Pready:
   - Write 0x000 → ID unchanged.
   - Write 0x041 (misaligned) → no register changes.
   - Read 0x100 (out of range) → Prdata=0.
5. WAIT_STATES=2: drop Psel after 1 Penable cycle of a write to 0x010 ← 32'hFFFF_FFFF → no Pready; 0x010 still reads 0. Next transfer completes normally.
6. Assert Hresetn=0 mid-ACCESS of a write to 0x014 → outputs 0 immediately; after release, 0x014 reads 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, default ID word and responder FSM states.
package apb_pkg;

    localparam int unsigned APB_DATA_W   = 32;
    localparam int unsigned APB_OFFSET_W = 12;

    localparam logic [APB_DATA_W-1:0] APB_DEFAULT_ID = 32'hA5B0_0001;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } apb_state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loads a count, decrements to zero, flags zero.
module apb_wait_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             count_en,
    output logic             is_zero
);

    logic [Width-1:0] count_q;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign is_zero = (count_q == '0);

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer register bank with read-only ID at index 0 and programmable wait states.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned            NUM_REGS    = 16,
    parameter int unsigned            WAIT_STATES = 0,
    parameter logic [APB_DATA_W-1:0]  ID_VALUE    = APB_DEFAULT_ID
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Psel,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [APB_DATA_W-1:0] Paddr,
    input  logic [APB_DATA_W-1:0] Pwdata,
    output logic [APB_DATA_W-1:0] Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    apb_state_e            state_q, state_d;
    logic [AW-1:0]         idx;
    logic [AW-1:0]         idx_q;
    logic                  write_q;
    logic                  err_q;
    logic                  addr_err;
    logic                  setup;
    logic                  complete;
    logic                  cnt_zero;
    logic [APB_DATA_W-1:0] rd_word;
    logic [APB_DATA_W-1:0] prdata_q;
    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
    logic                  unused_paddr;

    // Only the offset is decoded; upper address bits belong to the bridge.
    assign unused_paddr = ^Paddr[APB_DATA_W-1:APB_OFFSET_W];

    assign idx = Paddr[AW+1:2];

    // Setup-cycle decode: access strobes and error classification.
    always_comb begin
        setup    = Psel && !Penable && (state_q == StIdle);
        complete = Psel && Penable && Pready;
        addr_err = (Paddr[1:0] != 2'b00)
                || (Paddr[APB_OFFSET_W-1:AW+2] != '0)
                || (Pwrite && (idx == '0));
        rd_word  = (idx == '0) ? ID_VALUE : regs_q[idx];
    end

    apb_wait_counter #(
        .Width(4)
    ) u_wait_counter (
        .clk       (Hclk),
        .rst_n     (Hresetn),
        .load      (setup),
        .load_value(4'(WAIT_STATES)),
        .count_en  (state_q == StAccess),
        .is_zero   (cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: Penable without a prior setup is ignored in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!Psel || complete) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: ready purely from registered state and counter.
    always_comb begin
        Pready  = (state_q == StAccess) && cnt_zero;
        Pslverr = Pready && err_q;
    end

    // Latch the transfer attributes at setup so address changes in access are ignored.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (setup) begin
            idx_q   <= idx;
            write_q <= Pwrite;
            err_q   <= addr_err;
        end
    end

    // Read data captured at setup, cleared when the transfer ends or aborts.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            prdata_q <= '0;
        end else if (setup) begin
            prdata_q <= (Pwrite || addr_err) ? '0 : rd_word;
        end else if ((state_q == StAccess) && (complete || !Psel)) begin
            prdata_q <= '0;
        end
    end

    assign Prdata = prdata_q;

    // Register array; Pwdata is sampled on the completion edge only.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (complete && write_q && !err_q) begin
            regs_q[idx_q] <= Pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench: three register banks (0, 3 and 2 wait states) on a shared APB bus.
module tb_apb_slave_regbank;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int          ws_of [3] = '{0, 3, 2};
    logic [31:0] mdl [3][16];
    int          vectors;
    int          miscompares;
    int          cyc;

    apb_slave_regbank #(.NUM_REGS(16), .WAIT_STATES(0)) dut0 (
        .Hclk(hclk), .Hresetn(hresetn), .Psel(psel[0]), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[0]), .Pready(pready[0]),
        .Pslverr(pslverr[0])
    );
    apb_slave_regbank #(.NUM_REGS(16), .WAIT_STATES(3)) dut3 (
        .Hclk(hclk), .Hresetn(hresetn), .Psel(psel[1]), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[1]), .Pready(pready[1]),
        .Pslverr(pslverr[1])
    );
    apb_slave_regbank #(.NUM_REGS(16), .WAIT_STATES(2)) dut2 (
        .Hclk(hclk), .Hresetn(hresetn), .Psel(psel[2]), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[2]), .Pready(pready[2]),
        .Pslverr(pslverr[2])
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Error rules for a 16-entry bank: misaligned, beyond the bank, or a write to the ID.
    function automatic bit is_err(input bit wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[11:6] != 6'd0) || (wr && (a[5:2] == 4'd0));
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        if (is_err(1'b0, a)) return 32'd0;
        if (a[5:2] == 4'd0) return ID;
        return mdl[d][a[5:2]];
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) mdl[d][i] = 32'd0;
    endtask

    // One complete transfer; starts just after a rising edge and ends just after one.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        int          n;
        bit          err;
        logic [31:0] exp_rd;
        logic [3:0]  ix;
        err    = is_err(wr, a);
        exp_rd = model_read(d, a);
        ix     = a[5:2];
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge hclk); #1;
        penable = 1'b1;
        paddr   = $urandom;
        n = 0;
        @(negedge hclk);
        while (!pready[d] && n < 40) begin
            @(posedge hclk); #1;
            @(negedge hclk);
            n++;
        end
        check("latency", n, ws_of[d]);
        if (pready[d]) begin
            check("pslverr", {31'd0, pslverr[d]}, {31'd0, err});
            if (!wr) check("prdata", prdata[d], exp_rd);
        end
        @(posedge hclk); #1;
        psel[d] = 1'b0; penable = 1'b0;
        if (wr && !err) mdl[d][ix] = wd;
    endtask

    initial begin
        int c0;
        int d;
        bit wr;
        int r;
        logic [3:0]  ix;
        logic [31:0] a;
        vectors = 0; miscompares = 0; cyc = 0;
        hresetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        clear_model();
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        for (int i = 0; i < 3; i++) begin
            check("rst_pready", {31'd0, pready[i]}, 32'd0);
            check("rst_pslverr", {31'd0, pslverr[i]}, 32'd0);
            check("rst_prdata", prdata[i], 32'd0);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // ID and empty register, zero wait
        xfer(0, 1'b0, 32'h000, 32'd0);
        xfer(0, 1'b0, 32'h004, 32'd0);

        // Back-to-back write then read: two cycles each
        c0 = cyc;
        xfer(0, 1'b1, 32'h008, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h008, 32'd0);
        check("b2b_cycles", cyc - c0, 32'd4);

        // Three wait states
        xfer(1, 1'b1, 32'h03C, 32'h1234_5678);
        xfer(1, 1'b0, 32'h03C, 32'd0);

        // Error responses leave registers alone
        xfer(0, 1'b1, 32'h000, 32'hFFFF_0000);
        xfer(0, 1'b0, 32'h000, 32'd0);
        xfer(0, 1'b1, 32'h041, 32'h5555_AAAA);
        xfer(0, 1'b0, 32'h040, 32'd0);
        xfer(0, 1'b0, 32'h100, 32'd0);
        xfer(0, 1'b0, 32'h008, 32'd0);

        // Abort after one access cycle with two wait states
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'hFFFF_FFFF;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(negedge hclk);
        check("abort_pready_acc", {31'd0, pready[2]}, 32'd0);
        @(posedge hclk); #1;
        psel[2] = 1'b0; penable = 1'b0;
        @(negedge hclk);
        check("abort_pready_idle", {31'd0, pready[2]}, 32'd0);
        @(posedge hclk); #1;
        xfer(2, 1'b0, 32'h010, 32'd0);
        xfer(2, 1'b1, 32'h010, 32'h0BAD_CAFE);
        xfer(2, 1'b0, 32'h010, 32'd0);

        // Penable without setup is ignored
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h000;
        @(negedge hclk);
        check("stray_penable", {31'd0, pready[0]}, 32'd0);
        @(posedge hclk); #1;
        psel[0] = 1'b0; penable = 1'b0;

        // Reset in the middle of an access phase
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h014; pwdata = 32'hCAFE_F00D;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(negedge hclk);
        check("midrst_pready_before", {31'd0, pready[1]}, 32'd0);
        #2 hresetn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("midrst_pready", {31'd0, pready[i]}, 32'd0);
            check("midrst_prdata", prdata[i], 32'd0);
        end
        clear_model();
        @(posedge hclk); #1;
        psel = '0; penable = 1'b0; hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer(1, 1'b0, 32'h014, 32'd0);
        xfer(1, 1'b0, 32'h03C, 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            d  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            ix = 4'($urandom_range(0, 15));
            a  = {26'd0, ix, 2'b00};
            if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
            else if (r == 8) a[11:6] = 6'($urandom_range(1, 63));
            else if (r == 9) a[31:12] = 20'($urandom);
            xfer(d, wr, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
